keypad_display_scan: RTL and testbench

Output-side counterpart of the keypad scanner. The scanner drives columns and reads rows to produce key codes; this block takes those codes back out through a time-multiplexed common-anode 7-segment display. It synchronises and debounces the scanner's value/valid pair and turns each physical press into a single event. Each accepted digit is shifted into a right-entry digit buffer, and the block scans the buffer onto the display digits. It sits between the keypad scanner and the board display pins.

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/key_debounce.sv | 110 +++++++++++
 rtl/keypad_display_scan.sv | 121 ++++++++++++
 tb/tb_keypad_display_scan.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared debounce state type, blank pattern and
// active-low hex to 7-segment decode ({g,f,e,d,c,b,a}).
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } dbnc_state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] seg7_hex(input logic [3:0] h);
      logic [6:0] s;
      s = SEG_BLANK;
      case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop sync of the scanner's value/valid pair and a
// press/release debounce FSM that emits one event per physical press.
// Ports: clk, reset (sync, active-high), key_value[3:0], key_valid
// (both async) -> key_event (1-cycle pulse), key_code[3:0] (last press).
module key_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE = 200000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key_value,
   input  logic       key_valid,
   output logic       key_event,
   output logic [3:0] key_code
);

   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam logic [DW-1:0] TERM = DW'(DEBOUNCE - 1);

   logic          sv_meta_q, sv_meta_d;
   logic          sv_q, sv_d;
   logic [3:0]    sval_meta_q, sval_meta_d;
   logic [3:0]    sval_q, sval_d;
   dbnc_state_e   state_q, state_d;
   logic [3:0]    cand_q, cand_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic [DW-1:0] dcnt_inc;
   logic          key_event_q, key_event_d;
   logic [3:0]    key_code_q, key_code_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         sv_meta_q   <= 1'b0;
         sv_q        <= 1'b0;
         sval_meta_q <= '0;
         sval_q      <= '0;
         state_q     <= IDLE;
         cand_q      <= '0;
         dcnt_q      <= '0;
         key_event_q <= 1'b0;
         key_code_q  <= '0;
      end else begin
         sv_meta_q   <= sv_meta_d;
         sv_q        <= sv_d;
         sval_meta_q <= sval_meta_d;
         sval_q      <= sval_d;
         state_q     <= state_d;
         cand_q      <= cand_d;
         dcnt_q      <= dcnt_d;
         key_event_q <= key_event_d;
         key_code_q  <= key_code_d;
      end
   end

   // The cycle that enters PRESS_WAIT (or RELEASE_WAIT) is the first
   // stable cycle, so the terminal test uses the incremented count.
   always_comb begin
      sv_meta_d   = key_valid;
      sv_d        = sv_meta_q;
      sval_meta_d = key_value;
      sval_d      = sval_meta_q;
      state_d     = state_q;
      cand_d      = cand_q;
      dcnt_d      = dcnt_q;
      key_event_d = 1'b0;
      key_code_d  = key_code_q;
      dcnt_inc    = dcnt_q + DW'(1);
      case (state_q)
         IDLE: begin
            if (sv_q) begin
               state_d = PRESS_WAIT;
               cand_d  = sval_q;
               dcnt_d  = '0;
            end
         end
         PRESS_WAIT: begin
            if (!sv_q || (sval_q != cand_q)) begin
               state_d = IDLE;
            end else if (dcnt_inc >= TERM) begin
               state_d     = HELD;
               key_event_d = 1'b1;
               key_code_d  = cand_q;
            end else begin
               dcnt_d = dcnt_inc;
            end
         end
         HELD: begin
            if (!sv_q) begin
               state_d = RELEASE_WAIT;
               dcnt_d  = '0;
            end
         end
         RELEASE_WAIT: begin
            if (sv_q) begin
               state_d = HELD;
            end else if (dcnt_inc >= TERM) begin
               state_d = IDLE;
            end else begin
               dcnt_d = dcnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign key_event = key_event_q;
   assign key_code  = key_code_q;

endmodule

// File: rtl/keypad_display_scan.sv
// keypad_display_scan: debounced key entry into a right-entry digit
// buffer, scanned onto a common-anode 7-segment display.
// Ports: clk, reset (sync, active-high), key_value[3:0], key_valid,
// clear -> key_event, key_code[3:0], digits[4*DIGITS-1:0], count,
// an[DIGITS-1:0] (active-low), seg[6:0] {g..a} (active-low).
module keypad_display_scan
   import keypad_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DEBOUNCE    = 200000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [3:0]                   key_value,
   input  logic                         key_valid,
   input  logic                         clear,
   output logic                         key_event,
   output logic [3:0]                   key_code,
   output logic [4*DIGITS-1:0]          digits,
   output logic [$clog2(DIGITS+1)-1:0]  count,
   output logic [DIGITS-1:0]            an,
   output logic [6:0]                   seg
);

   localparam int CW = $clog2(DIGITS + 1);
   localparam int IW = $clog2(DIGITS);
   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic                ev;
   logic [3:0]          code;
   logic [4*DIGITS-1:0] digits_q, digits_d;
   logic [CW-1:0]       count_q, count_d;
   logic [RW-1:0]       rcnt_q, rcnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic [3:0]          nib;

   key_debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_dbnc (
      .clk       (clk),
      .reset     (reset),
      .key_value (key_value),
      .key_valid (key_valid),
      .key_event (ev),
      .key_code  (code)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         digits_q <= '0;
         count_q  <= '0;
         rcnt_q   <= '0;
         idx_q    <= '0;
         an_q     <= '1;
         seg_q    <= SEG_BLANK;
      end else begin
         digits_q <= digits_d;
         count_q  <= count_d;
         rcnt_q   <= rcnt_d;
         idx_q    <= idx_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end

   // Clear takes priority over a coincident press.
   always_comb begin
      digits_d = digits_q;
      count_d  = count_q;
      if (clear) begin
         digits_d = '0;
         count_d  = '0;
      end else if (ev) begin
         digits_d = {digits_q[4*DIGITS-5:0], code};
         if (count_q != CW'(DIGITS)) begin
            count_d = count_q + CW'(1);
         end
      end
   end

   always_comb begin
      rcnt_d = rcnt_q + RW'(1);
      idx_d  = idx_q;
      if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
         rcnt_d = '0;
         if (idx_q == IW'(DIGITS - 1)) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end
   end

   // Positions at or above count are blanked but still scanned.
   always_comb begin
      nib  = '0;
      an_d = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            nib     = digits_q[4*i +: 4];
            an_d[i] = 1'b0;
         end
      end
      if (CW'(idx_q) >= count_q) begin
         seg_d = SEG_BLANK;
      end else begin
         seg_d = seg7_hex(nib);
      end
   end

   assign key_event = ev;
   assign key_code  = code;
   assign digits    = digits_q;
   assign count     = count_q;
   assign an        = an_q;
   assign seg       = seg_q;

endmodule

// File: tb/tb_keypad_display_scan.sv
// tb_keypad_display_scan: table-driven, hand-written and random key
// sequences checked every cycle against a press/scan reference model.
module tb_keypad_display_scan;

   localparam int DIG  = 4;
   localparam int RDIV = 4;
   localparam int DEB  = 3;
   localparam int LAT  = 2 + DEB;
   localparam logic [6:0] HEX [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       key_value;
   logic             key_valid;
   logic             clear;
   logic             key_event;
   logic [3:0]       key_code;
   logic [4*DIG-1:0] digits;
   logic [2:0]       count;
   logic [DIG-1:0]   an;
   logic [6:0]       seg;

   always #5 clk = ~clk;

   keypad_display_scan #(
      .DIGITS      (DIG),
      .REFRESH_DIV (RDIV),
      .DEBOUNCE    (DEB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .key_value (key_value),
      .key_valid (key_valid),
      .clear     (clear),
      .key_event (key_event),
      .key_code  (key_code),
      .digits    (digits),
      .count     (count),
      .an        (an),
      .seg       (seg)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: pins reach the press logic two cycles late; a
   // press is accepted on its DEB-th consecutive present cycle once
   // the key has been absent for DEB cycles since the last press.
   int         m_n;
   bit         m_s1v, m_s2v;
   logic [3:0] m_s1val, m_s2val;
   bit         m_armed;
   int         m_r, m_z;
   bit         m_ev;
   logic [3:0] m_code;
   logic [3:0] m_buf [DIG];
   int         m_cnt;
   logic [DIG-1:0] m_an;
   logic [6:0] m_seg;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic [4*DIG-1:0] m_digits();
      logic [4*DIG-1:0] d;
      d = '0;
      for (int i = 0; i < DIG; i++) d[4*i +: 4] = m_buf[i];
      return d;
   endfunction

   task automatic model_edge(input bit r, input bit v,
                             input logic [3:0] val, input bit c);
      int  idx;
      bit  pv;
      logic [3:0] pval;
      if (r) begin
         m_n = 0; m_s1v = 0; m_s2v = 0; m_s1val = 0; m_s2val = 0;
         m_armed = 1; m_r = 0; m_z = 0; m_ev = 0; m_code = 0;
         for (int i = 0; i < DIG; i++) m_buf[i] = 0;
         m_cnt = 0; m_an = '1; m_seg = 7'h7F;
      end else begin
         idx = (m_n / RDIV) % DIG;
         m_n++;
         m_an = '1;
         m_an[idx] = 1'b0;
         m_seg = (idx < m_cnt) ? HEX[m_buf[idx]] : 7'h7F;
         if (c) begin
            for (int i = 0; i < DIG; i++) m_buf[i] = 0;
            m_cnt = 0;
         end else if (m_ev) begin
            for (int i = DIG - 1; i > 0; i--) m_buf[i] = m_buf[i-1];
            m_buf[0] = m_code;
            if (m_cnt < DIG) m_cnt++;
         end
         pv = m_s2v; pval = m_s2val;
         m_s2v = m_s1v; m_s2val = m_s1val;
         m_s1v = v; m_s1val = val;
         m_ev = 0;
         if (pv) begin m_r++; m_z = 0; end
         else begin m_z++; m_r = 0; end
         if (m_armed && pv && m_r == DEB) begin
            m_ev = 1; m_code = pval; m_armed = 0;
         end else if (!m_armed && !pv && m_z >= DEB) begin
            m_armed = 1;
         end
      end
   endtask

   task automatic step(input bit r, input bit v,
                       input logic [3:0] val, input bit c);
      reset = r; key_valid = v; key_value = val; clear = c;
      @(posedge clk);
      model_edge(r, v, val, c);
      #1;
      chk("key_event", key_event, m_ev);
      chk("key_code", key_code, m_code);
      chk("digits", digits, m_digits());
      chk("count", count, m_cnt);
      chk("an", an, m_an);
      chk("seg", seg, m_seg);
   endtask

   typedef struct {
      logic [3:0]  val;
      int          hold;
      int          gap;
      bit          clr;
      logic [15:0] dig;
      int          cnt;
      logic [3:0]  code;
      int          events;
      logic [3:0]  scan_an;
      logic [6:0]  scan_seg;
   } vec_t;

   vec_t       tbl [9];
   int         n_ev, first, s_no;
   bit         found, cbit;
   logic [3:0] rv;
   int         h, g;

   initial begin
      tbl[0] = '{4'h5, 20, 10, 1'b0, 16'h0005, 1, 4'h5, 1, 4'hE, 7'h12};
      tbl[1] = '{4'h1, 6, 6, 1'b0, 16'h0051, 2, 4'h1, 1, 4'hF, 7'h7F};
      tbl[2] = '{4'h2, 6, 6, 1'b0, 16'h0512, 3, 4'h2, 1, 4'hF, 7'h7F};
      tbl[3] = '{4'h3, 6, 6, 1'b0, 16'h5123, 4, 4'h3, 1, 4'hB, 7'h79};
      tbl[4] = '{4'h4, 6, 6, 1'b0, 16'h1234, 4, 4'h4, 1, 4'hD, 7'h30};
      tbl[5] = '{4'hA, 6, 6, 1'b0, 16'h234A, 4, 4'hA, 1, 4'h7, 7'h24};
      tbl[6] = '{4'h7, 6, 6, 1'b1, 16'h0000, 0, 4'h7, 1, 4'hE, 7'h7F};
      tbl[7] = '{4'h9, 2, 6, 1'b0, 16'h0000, 0, 4'h7, 0, 4'hF, 7'h7F};
      tbl[8] = '{4'hC, 3, 6, 1'b0, 16'h000C, 1, 4'hC, 1, 4'h7, 7'h7F};

      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      for (int i = 0; i < 40; i++) step(0, 0, 0, 0);

      for (int i = 0; i < 9; i++) begin
         n_ev = 0; first = -1; s_no = 0;
         for (int s = 1; s <= tbl[i].hold; s++) begin
            s_no++;
            cbit = tbl[i].clr && (s == LAT + 1);
            step(0, 1, tbl[i].val, cbit);
            if (key_event) begin n_ev++; if (first < 0) first = s_no; end
         end
         for (int s = 0; s < tbl[i].gap; s++) begin
            s_no++;
            step(0, 0, tbl[i].val, 0);
            if (key_event) begin n_ev++; if (first < 0) first = s_no; end
         end
         chk("tbl_events", n_ev, tbl[i].events);
         if (tbl[i].events > 0) chk("tbl_latency", first, LAT);
         chk("tbl_digits", digits, tbl[i].dig);
         chk("tbl_count", count, tbl[i].cnt);
         chk("tbl_code", key_code, tbl[i].code);
         if (tbl[i].scan_an != 4'hF) begin
            found = 0;
            for (int s = 0; s < 3 * DIG * RDIV && !found; s++) begin
               step(0, 0, tbl[i].val, 0);
               if (an == tbl[i].scan_an) found = 1;
            end
            chk("scan_an", an, tbl[i].scan_an);
            chk("scan_seg", seg, tbl[i].scan_seg);
         end
      end

      n_ev = 0;
      for (int k = 0; k < 4; k++) begin
         for (int s = 0; s < 2; s++) begin
            step(0, (k % 2) == 0, 4'h9, 0);
            if (key_event) n_ev++;
         end
      end
      for (int s = 0; s < 8; s++) begin
         step(0, 0, 4'h9, 0);
         if (key_event) n_ev++;
      end
      chk("bounce_events", n_ev, 0);
      chk("bounce_digits", digits, 16'h000C);

      n_ev = 0;
      for (int s = 0; s < 30; s++) begin
         step(0, !((s >= 8 && s < 10) || (s >= 12 && s < 14) || s >= 18),
              4'h6, 0);
         if (key_event) n_ev++;
      end
      chk("relbounce_events", n_ev, 1);
      chk("relbounce_digits", digits, 16'h00C6);
      chk("relbounce_count", count, 2);

      for (int k = 0; k < 40; k++) begin
         rv = 4'($urandom_range(0, 15));
         h  = $urandom_range(1, 7);
         g  = $urandom_range(1, 7);
         for (int s = 0; s < h; s++) begin
            cbit = ($urandom_range(0, 19) == 0);
            step(0, 1, rv, cbit);
         end
         for (int s = 0; s < g; s++) begin
            cbit = ($urandom_range(0, 19) == 0);
            step(0, 0, rv, cbit);
         end
      end

      for (int s = 0; s < 10; s++) step(0, 0, 4'h8, 0);
      n_ev = 0;
      for (int s = 0; s < 4; s++) begin
         step(0, 1, 4'h8, 0);
         if (key_event) n_ev++;
      end
      for (int s = 0; s < 2; s++) begin
         step(1, 1, 4'h8, 0);
         if (key_event) n_ev++;
      end
      chk("rstpress_early", n_ev, 0);
      n_ev = 0; first = -1;
      for (int s = 1; s <= 12; s++) begin
         step(0, 1, 4'h8, 0);
         if (key_event) begin n_ev++; if (first < 0) first = s; end
      end
      for (int s = 0; s < 10; s++) step(0, 0, 4'h8, 0);
      chk("rstpress_events", n_ev, 1);
      chk("rstpress_latency", first, DEB + 2);
      chk("rstpress_digits", digits, 16'h0008);
      chk("rstpress_count", count, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
